sha256_stream_padder: RTL and testbench

Message front-end for the SHA-256/224 core. Accepts a message as a stream of big-endian 32-bit words and builds 512-bit blocks with FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit message bit length. It drives the core's `init`/`next` handshake block by block and returns the final digest. It sits between the message source and the hash core, acting as the initiator on the core's block interface.

---
 rtl/sha256_stream_padder.sv | 212 +++++++++++++++++++++
 tb/tb_sha256_stream_padder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_padder.sv
// Purpose: SHA-256/224 message padder; packs a big-endian word stream into 512-bit blocks and drives the core's init/next handshake.
// Latency: 1 word/cycle in FILL, 1 cycle ISSUE->WAIT, digest_valid 2 cycles after the final block's digest is seen.
// Backpressure: s_ready is high only in FILL; the padder stalls in ISSUE until core_ready, and in WAIT until core_valid_digest.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   mode                        1 = SHA-256, 0 = SHA-224 (latched on first word of a message)
//   s_valid/s_ready/s_data      message word stream, byte 0 in [31:24]
//   s_last, s_bytes             final word marker, valid bytes in final word (0 means 4)
//   core_init/core_next         one-cycle block pulses to the core
//   core_mode, core_block       latched mode and current block (word 0 in [511:480])
//   core_ready, core_valid_digest, core_digest   core status and result
//   digest_valid, digest        final hash pulse and held hash
//   busy                        message in progress
module sha256_stream_padder (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         mode,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  input  logic [1:0]   s_bytes,
  output logic         core_init,
  output logic         core_next,
  output logic         core_mode,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic         core_valid_digest,
  input  logic [255:0] core_digest,
  output logic         digest_valid,
  output logic [255:0] digest,
  output logic         busy
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] blk [16];
  logic [3:0]  widx;
  logic [60:0] nbytes;
  logic        first_blk;
  logic        final_blk;
  logic        extra_blk;

  logic        accept;
  logic [2:0]  last_n;
  logic [60:0] nbytes_nxt;
  logic [63:0] bitlen_nxt;
  logic [63:0] bitlen_cur;
  logic [31:0] keep_mask;
  logic [31:0] pad_bit;
  logic [31:0] last_word;
  logic [4:0]  free_idx;
  logic        len_fits;
  logic [31:0] pad_blk [16];
  logic [31:0] extra    [16];

  assign s_ready = (state == FILL);
  assign accept  = s_valid && s_ready;

  always_comb begin
    for (int j = 0; j < 16; j++) begin
      core_block[511-32*j -: 32] = blk[j];
    end
  end

  // Padded image of the block if the current word is the last one.
  always_comb begin
    last_n     = (s_last && s_bytes != 2'd0) ? {1'b0, s_bytes} : 3'd4;
    nbytes_nxt = nbytes + 61'(last_n);
    bitlen_nxt = {nbytes_nxt, 3'b000};
    bitlen_cur = {nbytes, 3'b000};
    keep_mask  = 32'hFFFF_FFFF;
    pad_bit    = 32'h0000_0000;
    case (s_bytes)
      2'd1: begin keep_mask = 32'hFF00_0000; pad_bit = 32'h0080_0000; end
      2'd2: begin keep_mask = 32'hFFFF_0000; pad_bit = 32'h0000_8000; end
      2'd3: begin keep_mask = 32'hFFFF_FF00; pad_bit = 32'h0000_0080; end
      default: begin keep_mask = 32'hFFFF_FFFF; pad_bit = 32'h0000_0000; end
    endcase
    last_word = (s_data & keep_mask) | pad_bit;
    free_idx  = {1'b0, widx} + ((last_n == 3'd4) ? 5'd2 : 5'd1);
    len_fits  = (free_idx <= 5'd14);

    for (int j = 0; j < 16; j++) begin
      if (5'(j) < {1'b0, widx}) begin
        pad_blk[j] = blk[j];
      end else if (5'(j) == {1'b0, widx}) begin
        pad_blk[j] = last_word;
      end else if ((5'(j) == {1'b0, widx} + 5'd1) && (last_n == 3'd4)) begin
        pad_blk[j] = 32'h8000_0000;
      end else begin
        pad_blk[j] = 32'h0000_0000;
      end
    end
    if (len_fits) begin
      pad_blk[14] = bitlen_nxt[63:32];
      pad_blk[15] = bitlen_nxt[31:0];
    end

    // The 0x80 spills into the extra block only when the message filled the
    // previous block exactly, i.e. the byte count is a multiple of 64.
    for (int j = 0; j < 16; j++) begin
      extra[j] = 32'h0000_0000;
    end
    if (nbytes[5:0] == 6'd0) begin
      extra[0] = 32'h8000_0000;
    end
    extra[14] = bitlen_cur[63:32];
    extra[15] = bitlen_cur[31:0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= FILL;
      for (int j = 0; j < 16; j++) begin
        blk[j] <= 32'h0;
      end
      widx         <= 4'd0;
      nbytes       <= 61'd0;
      first_blk    <= 1'b1;
      final_blk    <= 1'b0;
      extra_blk    <= 1'b0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_mode    <= 1'b0;
      digest_valid <= 1'b0;
      digest       <= 256'h0;
      busy         <= 1'b0;
    end else begin
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      digest_valid <= 1'b0;
      case (state)
        FILL: begin
          if (accept) begin
            nbytes <= nbytes_nxt;
            if (!busy) begin
              busy      <= 1'b1;
              core_mode <= mode;
            end
            if (s_last) begin
              for (int j = 0; j < 16; j++) begin
                blk[j] <= pad_blk[j];
              end
              final_blk <= len_fits;
              extra_blk <= !len_fits;
              state     <= ISSUE;
            end else begin
              blk[widx] <= s_data;
              if (widx == 4'd15) begin
                final_blk <= 1'b0;
                state     <= ISSUE;
              end else begin
                widx <= widx + 4'd1;
              end
            end
          end
        end
        ISSUE: begin
          if (core_ready) begin
            core_init <= first_blk;
            core_next <= !first_blk;
            first_blk <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // While our pulse is still high the core has not yet cleared the
          // previous block's digest-valid, so it must not be trusted.
          if (core_valid_digest && !(core_init || core_next)) begin
            if (final_blk) begin
              digest <= core_digest;
              state  <= DONE;
            end else if (extra_blk) begin
              for (int j = 0; j < 16; j++) begin
                blk[j] <= extra[j];
              end
              final_blk <= 1'b1;
              extra_blk <= 1'b0;
              state     <= ISSUE;
            end else begin
              for (int j = 0; j < 16; j++) begin
                blk[j] <= 32'h0;
              end
              widx  <= 4'd0;
              state <= FILL;
            end
          end
        end
        default: begin
          digest_valid <= 1'b1;
          for (int j = 0; j < 16; j++) begin
            blk[j] <= 32'h0;
          end
          widx      <= 4'd0;
          nbytes    <= 61'd0;
          final_blk <= 1'b0;
          extra_blk <= 1'b0;
          first_blk <= 1'b1;
          busy      <= 1'b0;
          state     <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Bench for sha256_stream_padder with a behavioural SHA-256/224 core model.
module tb_sha256_stream_padder;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         mode;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_last;
  logic [1:0]   s_bytes;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic [511:0] core_block;
  logic         core_ready;
  logic         core_valid_digest;
  logic [255:0] core_digest;
  logic         digest_valid;
  logic [255:0] digest;
  logic         busy;

  always #5 clk = ~clk;

  sha256_stream_padder dut (
    .clk(clk), .n_rst(n_rst), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_bytes(s_bytes),
    .core_init(core_init), .core_next(core_next), .core_mode(core_mode), .core_block(core_block),
    .core_ready(core_ready), .core_valid_digest(core_valid_digest), .core_digest(core_digest),
    .digest_valid(digest_valid), .digest(digest), .busy(busy)
  );

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, bb, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic logic [31:0] wd(input logic [511:0] b, input int j);
    return b[511-32*j -: 32];
  endfunction

  // Core model: digest-valid stays high until the next pulse edge, result 66 cycles after pulse.
  logic [255:0] core_st;
  int           core_cnt;
  logic [511:0] blk_log [64];
  logic         kind_log [64];
  int           blk_cnt = 0;
  int           both_err = 0;
  int           acc_cnt = 0;
  int           ready_viol = 0;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      core_ready        <= 1'b1;
      core_valid_digest <= 1'b0;
      core_digest       <= 256'h0;
      core_st           <= 256'h0;
      core_cnt          <= 0;
    end else if (core_init || core_next) begin
      core_st           <= sha_compress(core_init ? (core_mode ? IV256 : IV224) : core_st, core_block);
      core_valid_digest <= 1'b0;
      core_ready        <= 1'b0;
      core_cnt          <= 65;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_valid_digest <= 1'b1;
        core_ready        <= 1'b1;
        core_digest       <= core_st;
      end
    end
  end

  always @(posedge clk) begin
    if (n_rst && (core_init || core_next)) begin
      blk_log[blk_cnt % 64]  <= core_block;
      kind_log[blk_cnt % 64] <= core_init;
      blk_cnt                <= blk_cnt + 1;
      if (core_init && core_next) both_err <= both_err + 1;
    end
    if (n_rst && s_valid && s_ready) acc_cnt <= acc_cnt + 1;
  end

  always @(negedge clk) begin
    if (n_rst && s_ready && (!core_ready || core_init || core_next)) ready_viol <= ready_viol + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] msg_w [32];

  task automatic drive_msg(input int n, input logic [1:0] lb, input logic md, input logic with_last);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 5000) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = msg_w[k];
      s_last  = with_last && (k == n - 1);
      s_bytes = (k == n - 1) ? lb : 2'd0;
      mode    = md;
      if (s_ready) k++;
      guard++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_bytes = 2'd0;
    check("drive_timeout", 256'(k), 256'(n));
  endtask

  task automatic wait_digest(output int busy_viol);
    int c = 0;
    busy_viol = 0;
    while (!digest_valid && c < 3000) begin
      if (!busy) busy_viol++;
      @(negedge clk);
      c++;
    end
    check("digest_timeout", 256'(digest_valid), 256'(1));
  endtask

  typedef struct packed {
    logic         md;
    logic [4:0]   nw;
    logic [1:0]   lb;
    logic [511:0] words;
    logic [255:0] dig;
    logic [2:0]   nblk;
    logic [31:0]  f0, f14, f15, l0, l15;
  } vec_t;

  vec_t vt [4];

  initial begin
    int base, abase, bv, rv;
    logic [31:0] wtmp;
    logic [255:0] got;

    vt[0] = '{1'b1, 5'd1, 2'd3, {32'h61626300, 480'h0},
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
              3'd1, 32'h61626380, 32'h0, 32'h18, 32'h61626380, 32'h18};
    vt[1] = '{1'b0, 5'd1, 2'd3, {32'h61626300, 480'h0},
              {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0},
              3'd1, 32'h61626380, 32'h0, 32'h18, 32'h61626380, 32'h18};
    vt[2] = '{1'b1, 5'd14, 2'd0,
              {256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
               192'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071, 64'h0},
              256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1,
              3'd2, 32'h61626364, 32'h80000000, 32'h0, 32'h0, 32'h1c0};
    vt[3] = '{1'b1, 5'd16, 2'd0, 512'h0,
              256'hf5a5fd42d16a20302798ef6ed309979b43003d2320d9f0e8ea9831a92759fb4b,
              3'd2, 32'h0, 32'h0, 32'h0, 32'h80000000, 32'h200};

    n_rst = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0; s_bytes = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 256'(s_ready), 256'(1));
    check("rst_init_next", 256'({core_init, core_next}), 256'(0));
    check("rst_digest_valid", 256'(digest_valid), 256'(0));
    check("rst_digest", digest, 256'h0);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_core_mode", 256'(core_mode), 256'(0));
    check("rst_core_block", core_block[511:256] | core_block[255:0], 256'h0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 16; k++) msg_w[k] = wd(vt[v].words, k);
      base = blk_cnt;
      rv   = ready_viol;
      drive_msg(int'(vt[v].nw), vt[v].lb, vt[v].md, 1'b1);
      wait_digest(bv);
      got = vt[v].md ? digest : {digest[255:32], 32'h0};
      check($sformatf("v%0d_digest", v), got, vt[v].dig);
      check($sformatf("v%0d_core_mode", v), 256'(core_mode), 256'(vt[v].md));
      check($sformatf("v%0d_nblocks", v), 256'(blk_cnt - base), 256'(vt[v].nblk));
      check($sformatf("v%0d_first_is_init", v), 256'(kind_log[base % 64]), 256'(1));
      if (vt[v].nblk == 3'd2)
        check($sformatf("v%0d_second_is_next", v), 256'(kind_log[(base + 1) % 64]), 256'(0));
      check($sformatf("v%0d_first_w0", v), 256'(wd(blk_log[base % 64], 0)), 256'(vt[v].f0));
      check($sformatf("v%0d_first_w14", v), 256'(wd(blk_log[base % 64], 14)), 256'(vt[v].f14));
      check($sformatf("v%0d_first_w15", v), 256'(wd(blk_log[base % 64], 15)), 256'(vt[v].f15));
      check($sformatf("v%0d_last_w0", v), 256'(wd(blk_log[(base + int'(vt[v].nblk) - 1) % 64], 0)), 256'(vt[v].l0));
      check($sformatf("v%0d_last_w15", v), 256'(wd(blk_log[(base + int'(vt[v].nblk) - 1) % 64], 15)), 256'(vt[v].l15));
      check($sformatf("v%0d_busy_held", v), 256'(bv), 256'(0));
      check($sformatf("v%0d_ready_low_in_wait", v), 256'(ready_viol - rv), 256'(0));
      @(negedge clk);
      check($sformatf("v%0d_digest_valid_pulse", v), 256'(digest_valid), 256'(0));
      repeat (3) @(negedge clk);
    end

    // 112-byte two-block message with s_valid held across the first WAIT.
    for (int k = 0; k < 28; k++) begin
      for (int bb = 0; bb < 4; bb++) begin
        wtmp[31-8*bb -: 8] = 8'(8'h61 + (4*k + bb) / 8 + (4*k + bb) % 8);
      end
      msg_w[k] = wtmp;
    end
    base  = blk_cnt;
    abase = acc_cnt;
    rv    = ready_viol;
    drive_msg(28, 2'd0, 1'b1, 1'b1);
    wait_digest(bv);
    check("bp_digest", digest, 256'hcf5b16a778af8380036ce59e7b0492370b249b11e8f07a51afac45037afee9d1);
    check("bp_words_accepted", 256'(acc_cnt - abase), 256'(28));
    check("bp_nblocks", 256'(blk_cnt - base), 256'(2));
    check("bp_last_w12", 256'(wd(blk_log[(base + 1) % 64], 12)), 256'(32'h80000000));
    check("bp_last_w15", 256'(wd(blk_log[(base + 1) % 64], 15)), 256'(32'h380));
    check("bp_ready_low_in_wait", 256'(ready_viol - rv), 256'(0));
    repeat (3) @(negedge clk);

    // Reset while the first block of a longer message is being hashed.
    base = blk_cnt;
    drive_msg(16, 2'd0, 1'b0, 1'b0);
    for (int c = 0; c < 200 && blk_cnt == base; c++) @(negedge clk);
    check("mid_first_block_issued", 256'(blk_cnt - base), 256'(1));
    repeat (10) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_rst_s_ready", 256'(s_ready), 256'(1));
    check("mid_rst_init_next", 256'({core_init, core_next}), 256'(0));
    check("mid_rst_digest", digest, 256'h0);
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_core_mode", 256'(core_mode), 256'(0));
    check("mid_rst_core_block", core_block[511:256] | core_block[255:0], 256'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    msg_w[0] = 32'h61626300;
    base = blk_cnt;
    drive_msg(1, 2'd3, 1'b1, 1'b1);
    wait_digest(bv);
    check("post_rst_digest", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
    check("post_rst_nblocks", 256'(blk_cnt - base), 256'(1));
    check("post_rst_is_init", 256'(kind_log[base % 64]), 256'(1));
    check("never_both_pulses", 256'(both_err), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
